cache_controller: RTL
=====================

# cache_controller

Direct-mapped, write-through, no-write-allocate cache controller that sits between the CPU-side request port and the word-addressed main-memory RAM. It is the initiator of the RAM's `rd_en`/`wr_en`/`addr`/`w_data`/`r_data` interface. On a read miss it refills a 4-word line from RAM, then answers the CPU. Writes always go to RAM, and update the cache only on a hit.

## Interface
- `DATA_WIDTH`, 32, word width; matches RAM data width
- `ADDR_WIDTH`, 16, word address width; matches RAM address width
- `INDEX_BITS`, 6, line index width (64 lines)
- `OFFSET_BITS`, 2, word-in-line offset width (4 words/line)
- Derived: `TAG_BITS` = `ADDR_WIDTH`−`INDEX_BITS`−`OFFSET_BITS` (8)
- Address split: tag = `addr[15:8]`, index = `addr[7:2]`, offset = `addr[1:0]`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  CPU request present
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_WIDTH  word address
- `req_wdata`  in  DATA_WIDTH  write data
- `req_ready`  out  1  controller can accept a request
- `resp_valid`  out  1  one-cycle completion pulse (read data or write ack)
- `resp_rdata`  out  DATA_WIDTH  read data, valid with `resp_valid` on reads
- `mem_rd_en`  out  1  to RAM `rd_en`
- `mem_wr_en`  out  1  to RAM `wr_en`
- `mem_addr`  out  ADDR_WIDTH  to RAM `addr`
- `mem_wdata`  out  DATA_WIDTH  to RAM `w_data`
- `mem_rdata`  in  DATA_WIDTH  from RAM `r_data`; valid the cycle after `mem_rd_en`

## Operation
- FSM states: IDLE, LOOKUP, REFILL.
- **IDLE**
  - `req_ready = (state==IDLE)`.
  - On `req_valid && req_ready`, capture we/addr/wdata and go to LOOKUP.
  - Request fields are sampled only in the handshake cycle.
- **LOOKUP** (hit = valid[index] && tag[index]==req tag)
  - Read hit: `resp_rdata` ← line word; `resp_valid` ← 1; go to IDLE.
  - Read miss: go to REFILL. Issue counter ← 0; receive counter ← 0.
  - Write, hit or miss: `mem_wr_en` ← 1 with addr/wdata; `resp_valid` ← 1; go to IDLE.
    - On a hit, the cached word is also updated.
    - On a miss, cache state is unchanged.
- **REFILL**
  - Issue: `mem_rd_en` is high for 4 consecutive cycles. `mem_addr` = {tag, index, issue_cnt}, with word 0 first.
  - Receive: `mem_rdata` is captured the cycle after each issue, into data[index][recv_cnt].
  - On the 4th capture: set valid[index] and tag[index]; `resp_rdata` ← the requested word; `resp_valid` ← 1; go to IDLE.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- `resp_valid` is never high for 2 consecutive cycles for the same request. The CPU always accepts responses; there is no back-pressure.
- **Reset** (including mid-REFILL)
  - All valid bits cleared; state ← IDLE.
  - A partially refilled line is discarded.
  - `mem_rdata` arriving after reset is ignored.

## Timing
- Cycle 0 is the handshake cycle.
- Read hit: LOOKUP in cycle 1; `resp_valid` in cycle 2.
- Read miss:
  - `mem_rd_en` in cycles 2–5.
  - Captures at the end of cycles 3–6.
  - `resp_valid` in cycle 7.
- Write: `mem_wr_en` and `resp_valid` both in cycle 2.
- `req_ready` is high in the response cycle, so back-to-back requests are allowed.
- Reset values:
  - `resp_valid`, `resp_rdata`, `mem_rd_en`, `mem_wr_en`, `mem_addr`, `mem_wdata` = 0.
  - All valid bits = 0.
  - `req_ready` = 1 in the first cycle after reset deasserts.
- All outputs except `req_ready` are registered.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds output ports `hit_count` and `miss_count` (32 bits each).
  - `hit_count` increments on each read hit in LOOKUP; `miss_count` increments on each read miss.
  - Writes are not counted.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- `CACHE_STATS_EN` undefined: no counters and no ports.

## Structure
- Shared package `cache_pkg` holds:
  - the FSM state enum;
  - `TAG_BITS`/`INDEX_BITS`/`OFFSET_BITS` defaults;
  - address-field extraction functions.
- One sub-module, `cache_line_store`, holds:
  - the valid, tag and data arrays (flop-based, asynchronous read);
  - a word-write port and a line-valid/tag-set port;
  - a synchronous clear of the valid bits on `rst`.

## Test plan
The bench uses a RAM model preloaded with data = address.
- Reset, then read 0x0005:
  - `mem_rd_en` in cycles 2–5 with addr 0x0004–0x0007.
  - `resp_valid` in cycle 7 with `resp_rdata` = 0x00000005.
- Then read 0x0006:
  - `resp_valid` in cycle 2 with data 0x00000006.
  - No `mem_rd_en`; `hit_count` = 1 with `CACHE_STATS_EN`.
- Write 0x0006 = 0xDEADBEEF:
  - `mem_wr_en` in cycle 2 with addr 0x0006.
  - A following read of 0x0006 hits and returns 0xDEADBEEF.
- Read 0x0104 (same index as 0x0005, tag 0x01):
  - Miss; refill from 0x0104–0x0107; returns 0x00000104.
  - A following read of 0x0005 misses again.
- Write miss 0x0200 = 0x12345678:
  - RAM is written; no refill.
  - A following read of 0x0200 misses and returns 0x12345678.
- Assert `rst` in cycle 4 of a read-miss refill:
  - `mem_rd_en` = 0 in the next cycle and no `resp_valid`.
  - Re-reading the same address misses and refills fully.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the
// direct-mapped write-through cache controller.
package cache_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_INDEX_BITS  = 6;
    localparam int DEFAULT_OFFSET_BITS = 2;
    localparam int DEFAULT_TAG_BITS    = DEFAULT_ADDR_WIDTH - DEFAULT_INDEX_BITS - DEFAULT_OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL
    } cache_state_t;

    // Word address layout: {tag, index, offset}
    function automatic logic [DEFAULT_TAG_BITS-1:0] addr_tag(input logic [DEFAULT_ADDR_WIDTH-1:0] addr);
        return addr[DEFAULT_ADDR_WIDTH-1 -: DEFAULT_TAG_BITS];
    endfunction

    function automatic logic [DEFAULT_INDEX_BITS-1:0] addr_index(input logic [DEFAULT_ADDR_WIDTH-1:0] addr);
        return addr[DEFAULT_OFFSET_BITS +: DEFAULT_INDEX_BITS];
    endfunction

    function automatic logic [DEFAULT_OFFSET_BITS-1:0] addr_offset(input logic [DEFAULT_ADDR_WIDTH-1:0] addr);
        return addr[DEFAULT_OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Flop-based valid/tag/data arrays with asynchronous read, a word-write port
// and a line-valid/tag-set port; only the valid bits are cleared by reset.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
    parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS,
    parameter int TAG_BITS    = DEFAULT_TAG_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_word,
    input  logic                   word_we,
    input  logic [INDEX_BITS-1:0]  word_index,
    input  logic [OFFSET_BITS-1:0] word_offset,
    input  logic [DATA_WIDTH-1:0]  word_wdata,
    input  logic                   line_set,
    input  logic [INDEX_BITS-1:0]  line_index,
    input  logic [TAG_BITS-1:0]    line_tag
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (line_set) begin
            valid_q[line_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_set) begin
            tag_q[line_index] <= line_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[word_index][word_offset] <= word_wdata;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 4-word
// line refill. Define CACHE_STATS_EN to add saturating read hit/miss counters.
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
    parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

    cache_state_t state;

    logic                   req_we_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [DATA_WIDTH-1:0]  req_wdata_q;
    logic [OFFSET_BITS-1:0] issue_cnt;
    logic [OFFSET_BITS-1:0] recv_cnt;
    logic [OFFSET_BITS-1:0] next_issue;
    logic                   rd_pending;

    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_index;
    logic [OFFSET_BITS-1:0] req_offset;

    logic                   line_valid;
    logic [TAG_BITS-1:0]    line_tag;
    logic [DATA_WIDTH-1:0]  line_word;
    logic                   hit;

    logic                   word_we;
    logic [OFFSET_BITS-1:0] word_offset;
    logic [DATA_WIDTH-1:0]  word_wdata;
    logic                   line_set;

    assign req_tag    = addr_tag(req_addr_q);
    assign req_index  = addr_index(req_addr_q);
    assign req_offset = addr_offset(req_addr_q);
    assign next_issue = issue_cnt + 1'b1;
    assign hit        = line_valid && (line_tag == req_tag);
    assign req_ready  = (state == IDLE);

    cache_line_store #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .rd_index    (req_index),
        .rd_offset   (req_offset),
        .rd_valid    (line_valid),
        .rd_tag      (line_tag),
        .rd_word     (line_word),
        .word_we     (word_we),
        .word_index  (req_index),
        .word_offset (word_offset),
        .word_wdata  (word_wdata),
        .line_set    (line_set),
        .line_index  (req_index),
        .line_tag    (req_tag)
    );

    // Store writes: write-hit update in LOOKUP, refill captures in REFILL
    always_comb begin
        word_we     = 1'b0;
        word_offset = req_offset;
        word_wdata  = req_wdata_q;
        line_set    = 1'b0;
        if (!rst) begin
            case (state)
                LOOKUP: begin
                    if (req_we_q && hit) begin
                        word_we = 1'b1;
                    end
                end
                REFILL: begin
                    if (rd_pending) begin
                        word_we     = 1'b1;
                        word_offset = recv_cnt;
                        word_wdata  = mem_rdata;
                        line_set    = (recv_cnt == '1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            rd_pending  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_wr_en  <= 1'b0;
            rd_pending <= mem_rd_en;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_we_q    <= req_we;
                        req_addr_q  <= req_addr;
                        req_wdata_q <= req_wdata;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_we_q) begin
                        mem_wr_en  <= 1'b1;
                        mem_addr   <= req_addr_q;
                        mem_wdata  <= req_wdata_q;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (hit) begin
                        resp_rdata <= line_word;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rd_en) begin
                        if (issue_cnt == '1) begin
                            mem_rd_en <= 1'b0;
                        end else begin
                            issue_cnt <= next_issue;
                            mem_addr  <= {req_tag, req_index, next_issue};
                        end
                    end
                    // Earlier words are already in the store; the last one is still on the bus
                    if (rd_pending) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (recv_cnt == '1) begin
                            resp_rdata <= (recv_cnt == req_offset) ? mem_rdata : line_word;
                            resp_valid <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !req_we_q) begin
            if (hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + 1'b1;
                end
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule
